// File: rtl/ahb_region_pkg.sv
// Shared AHB-Lite encodings and the address region table for ahb_region_decoder.
// Unused table slots carry a zero mask with a non-zero base, so they can never match.
package ahb_region_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_e;

    localparam int unsigned MAX_SLAVES = 16;

    // Index 0 is the default slave and is never compared.
    localparam logic [31:0] REGION_BASE [MAX_SLAVES] = '{
        32'hFFFF_FFFF, 32'h0000_0000, 32'h0001_0000, 32'h0002_0000,
        32'h1000_0000, 32'h2000_0000, 32'h4000_0000, 32'h0800_0000,
        32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF
    };

    localparam logic [31:0] REGION_MASK [MAX_SLAVES] = '{
        32'h0000_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
        32'hF000_0000, 32'hF000_0000, 32'hC000_0000, 32'hF800_0000,
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000
    };

endpackage

// File: rtl/ahb_region_decoder_default_slave.sv
// Built-in default slave: two-cycle ERROR response for unmapped active transfers,
// plus sticky capture of the first faulting address and a saturating error count.
module ahb_default_slave
    import ahb_region_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel,
    input  logic              trans,
    input  logic              hready,
    input  logic [ADDR_W-1:0] haddr,
    input  logic              err_clr,
    output logic              ready,
    output hresp_e            resp,
    output logic              err_valid,
    output logic [ADDR_W-1:0] err_addr,
    output logic [CNT_W-1:0]  err_cnt
);

    ds_state_e state;
    logic      start;

    // An unmapped active transfer whose address phase completes this cycle.
    assign start = sel && trans && hready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= DS_IDLE;
            ready     <= 1'b1;
            resp      <= HRESP_OKAY;
            err_valid <= 1'b0;
            err_addr  <= '0;
            err_cnt   <= '0;
        end else begin
            unique case (state)
                DS_ERR1: begin
                    state <= DS_ERR2;
                    ready <= 1'b1;
                    resp  <= HRESP_ERROR;
                end
                default: begin
                    if (start) begin
                        state <= DS_ERR1;
                        ready <= 1'b0;
                        resp  <= HRESP_ERROR;
                    end else begin
                        state <= DS_IDLE;
                        ready <= 1'b1;
                        resp  <= HRESP_OKAY;
                    end
                end
            endcase

            // A new error in the clearing cycle wins over the clear.
            if (start) begin
                err_valid <= 1'b1;
                if (!err_valid || err_clr) begin
                    err_addr <= haddr;
                end
                if (err_clr) begin
                    err_cnt <= CNT_W'(1);
                end else if (err_cnt != '1) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end else if (err_clr) begin
                err_valid <= 1'b0;
                err_addr  <= '0;
                err_cnt   <= '0;
            end
        end
    end

endmodule

// File: rtl/ahb_region_decoder.sv
// AHB-Lite address decoder and slave-response multiplexer with a built-in
// default slave for unmapped addresses.
module ahb_region_decoder
    import ahb_region_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 8,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic [ADDR_W-1:0]            HADDR,
    input  logic [1:0]                   HTRANS,
    output logic [NUM_SLAVES-1:0]        HSEL,
    input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
    input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
    input  logic [NUM_SLAVES*2-1:0]      HRESP_S,
    output logic [DATA_W-1:0]            HRDATA,
    output logic                         HREADY,
    output logic [1:0]                   HRESP,
    input  logic                         err_clr,
    output logic                         err_valid,
    output logic [ADDR_W-1:0]            err_addr,
    output logic [CNT_W-1:0]             err_cnt
);

    logic [NUM_SLAVES-1:0] dsel_q;
    logic [NUM_SLAVES-1:0] slave_sel;
    logic                  trans_q;
    logic [ADDR_W-1:0]     addr_q;
    logic                  active;
    logic                  hit;
    logic                  ds_ready;
    hresp_e                ds_resp;

    assign active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);

    // Lowest matching region index wins; no match falls through to the default slave.
    always_comb begin
        HSEL = '0;
        hit  = 1'b0;
        for (int unsigned i = 1; i < NUM_SLAVES; i++) begin
            if (!hit && ((HADDR & ADDR_W'(REGION_MASK[4'(i)])) == ADDR_W'(REGION_BASE[4'(i)]))) begin
                HSEL[i] = 1'b1;
                hit     = 1'b1;
            end
        end
        if (!hit) begin
            HSEL[0] = 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dsel_q  <= NUM_SLAVES'(1);
            trans_q <= 1'b0;
            addr_q  <= '0;
        end else if (HREADY) begin
            dsel_q  <= HSEL;
            trans_q <= HTRANS[1];
            addr_q  <= HADDR;
        end
    end

    always_comb begin
        slave_sel    = dsel_q;
        slave_sel[0] = 1'b0;
        HRDATA       = '0;
        HREADY       = 1'b0;
        HRESP        = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (slave_sel[i]) begin
                HRDATA = HRDATA | HRDATA_S[i*DATA_W +: DATA_W];
                HREADY = HREADY | HREADYOUT_S[i];
                HRESP  = HRESP  | HRESP_S[i*2 +: 2];
            end
        end
        if (dsel_q[0]) begin
            HRDATA = '0;
            HREADY = ds_ready;
            HRESP  = ds_resp;
        end
    end

    ahb_default_slave #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_default_slave (
        .clk       (HCLK),
        .rst_n     (HRESETn),
        .sel       (HSEL[0]),
        .trans     (active),
        .hready    (HREADY),
        .haddr     (HADDR),
        .err_clr   (err_clr),
        .ready     (ds_ready),
        .resp      (ds_resp),
        .err_valid (err_valid),
        .err_addr  (err_addr),
        .err_cnt   (err_cnt)
    );

    // Data-phase bookkeeping must agree with the default slave's view of the error.
    always_ff @(posedge HCLK) begin
        if (HRESETn && dsel_q[0] && trans_q) begin
            assert (HRESP == HRESP_ERROR);
            if (CNT_W > 1 && !HREADY && err_cnt == CNT_W'(1)) begin
                assert (err_addr == addr_q);
            end
        end
    end

endmodule

// File: doc/ahb_region_decoder.md
Name: ahb_region_decoder

Overview:
Parametrised AHB-Lite address decoder and slave-response multiplexer, the successor to the fixed 8-slave decoder. It decodes HADDR against a package-defined base/mask region table to drive HSEL. It registers the data-phase selection and muxes HRDATA/HREADYOUT/HRESP back to the master. It contains a built-in default slave that issues the two-cycle AHB ERROR response for unmapped accesses, plus a sticky decode-error capture register.

Parameters:
NUM_SLAVES, 8, slave count including default slave at index 0 (2..16)
ADDR_W, 32, HADDR width
DATA_W, 32, HRDATA width
CNT_W, 8, width of saturating decode-error counter

Ports:
HCLK  in  1  clock
HRESETn  in  1  synchronous active-low reset
HADDR  in  ADDR_W  address-phase address
HTRANS  in  2  transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
HSEL  out  NUM_SLAVES  one-hot address-phase select; bit0 = default slave
HRDATA_S  in  NUM_SLAVES*DATA_W  per-slave read data; slice 0 ignored
HREADYOUT_S  in  NUM_SLAVES  per-slave ready; bit0 ignored
HRESP_S  in  NUM_SLAVES*2  per-slave response; slice 0 ignored
HRDATA  out  DATA_W  muxed read data
HREADY  out  1  muxed ready, also fed back to all slaves
HRESP  out  2  muxed response (OKAY=00, ERROR=01)
err_clr  in  1  clears error capture
err_valid  out  1  sticky: unmapped access seen
err_addr  out  ADDR_W  address of first unmapped access since clear
err_cnt  out  CNT_W  saturating count of unmapped accesses

Behaviour:
- Address decode is combinational. Slave i (1..N-1) matches when (HADDR & MASK[i]) == BASE[i].
- Lowest matching index wins. Overlapping regions are a configuration error; no runtime check.
- No match selects HSEL[0]. HSEL is exactly one-hot at all times, independent of HTRANS.
- dsel_q is a one-hot data-phase select, loaded from HSEL when HREADY=1 and held when HREADY=0.
- trans_q = HTRANS[1] and addr_q = HADDR, both captured under the same enable.
- Reset: dsel_q=bit0, trans_q=0, addr_q=0, FSM=IDLE. Output reset values: HREADY=1, HRESP=OKAY, HRDATA=0, err_valid=0, err_addr=0, err_cnt=0.
- Mux when dsel_q != bit0: HRDATA/HREADY/HRESP are taken from the selected slave. The mux is combinational with zero added latency.
- Mux when dsel_q = bit0: outputs come from the default slave. HRDATA is always 0.
- Default-slave FSM states: IDLE, ERR1, ERR2.
  - IDLE: HREADY=1, HRESP=OKAY.
  - IDLE -> ERR1 when the address phase selects bit0, HTRANS is NONSEQ or SEQ, and HREADY=1. The FSM is therefore in ERR1 during the data phase.
  - ERR1: HREADY=0, HRESP=ERROR; always -> ERR2.
  - ERR2: HREADY=1, HRESP=ERROR. The master's next address phase completes in this cycle.
  - ERR2 -> ERR1 if the new address phase is again an unmapped NONSEQ/SEQ; otherwise -> IDLE.
- IDLE/BUSY to an unmapped address: zero-wait OKAY with no error recorded.
- Error capture, on each ERR1 entry:
  - err_cnt increments and saturates at all-ones.
  - If err_valid=0, err_addr is loaded with the faulting HADDR and err_valid is set.
  - err_addr is held until cleared.
- err_clr=1 clears err_valid/err_addr/err_cnt.
  - If an ERR1 entry occurs in the same cycle, the new error wins: err_valid=1, err_addr=new address, err_cnt=1.
- Reset asserted mid-ERR1/ERR2: the next cycle shows the reset values. No ERROR completion is owed.
- A slave wait state (HREADYOUT_S=0) freezes dsel_q, so the response stays routed to that slave.

Decomposition:
- Package ahb_region_pkg holds:
  - the HTRANS/HRESP enum typedefs;
  - the region table as localparam arrays REGION_BASE[16]/REGION_MASK[16];
  - defaults:
    - S1 0x0000_0000/FFFF_0000
    - S2 0x0001_0000/FFFF_0000
    - S3 0x0002_0000/FFFF_0000
    - S4 0x1000_0000/F000_0000
    - S5 0x2000_0000/F000_0000
    - S6 0x4000_0000/C000_0000
    - S7 0x0800_0000/F800_0000
- One sub-module, ahb_default_slave: contains the FSM and error capture, with inputs sel/trans/hready/haddr/err_clr.

Test Plan:
1. Reset, then NONSEQ to 0x0001_0004 with slave 2 returning HRDATA=0xCAFE_0001, HREADYOUT=1 -> HSEL=0x04; next cycle HRDATA=0xCAFE_0001, HREADY=1, HRESP=OKAY.
2. NONSEQ to 0x8000_0000 (unmapped) -> HSEL=0x01. Data-phase cycle 1: HREADY=0, HRESP=01. Cycle 2: HREADY=1, HRESP=01. Then err_valid=1, err_addr=0x8000_0000, err_cnt=1.
3. Back-to-back unmapped NONSEQ 0x8000_0000 then 0x9000_0000 -> FSM goes ERR1, ERR2, ERR1, ERR2. err_cnt=2, err_addr stays 0x8000_0000.
4. IDLE to 0x8000_0000 -> HREADY=1, HRESP=OKAY, err_cnt unchanged.
5. Slave 4 (addr 0x1000_0010) holds HREADYOUT=0 for 3 cycles while HADDR changes to 0x0 -> HREADY=0 for 3 cycles, dsel_q stays slave 4, then completes OKAY.
6. err_clr pulsed in the same cycle as an ERR1 entry at 0xA000_0000 -> err_valid=1, err_addr=0xA000_0000, err_cnt=1. With CNT_W=2, 5 errors give err_cnt=3.
